// File: rtl/lsu_access_ctrl.sv
// Load/store access controller: turns one B/H/W request into word-aligned byte-lane memory
// cycles. Optional macro LSU_MISALIGN_SPLIT_EN enables splitting of word-crossing accesses.
module lsu_access_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     ld_data,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_we,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int PW = 2;
`else
    localparam int PW = 1;
`endif

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t                state_q;
    logic                  is_ld_q;
    logic                  err_q;
    logic [2:0]            f3_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           ld_data_q;

    logic                  accept;
    logic                  f3_legal;
    logic                  illegal;
    logic [1:0]            off;
    logic [3:0]            size_msk;
    logic [4*PW-1:0]       lane_msk;
    logic [32*PW-1:0]      wd_pair;
    logic [DM_ADDRESS-3:0] word_q;
    logic                  addr_unused;

    assign addr_unused = ^addr[31:DM_ADDRESS];

    function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] o,
                                            input logic [2:0] f3);
        logic [31:0] raw;
        raw = 32'(pair >> {o, 3'b000});
        case (f3)
            3'b000:  extract = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extract = {{16{raw[15]}}, raw[15:0]};
            3'b100:  extract = {24'b0, raw[7:0]};
            3'b101:  extract = {16'b0, raw[15:0]};
            default: extract = raw;
        endcase
    endfunction

    always_comb begin
        f3_legal = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default: f3_legal = 1'b0;
        endcase
    end

    assign accept = req_valid & req_ready & (MemRead | MemWrite);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [2:0]            sz;
    logic                  split;
    logic [31:0]           first_q;
    logic [DM_ADDRESS-3:0] word_nxt;

    assign illegal  = ~f3_legal | (~MemRead & Funct3[2]);
    assign sz       = (f3_q[1:0] == 2'b00) ? 3'd1 : (f3_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign split    = ({1'b0, off} + sz) > 3'd4;
    assign word_nxt = word_q + (DM_ADDRESS-2)'(1);
`else
    logic misalign;

    // Without splitting, only naturally aligned H/W accesses can be served in one word.
    assign misalign = ((Funct3[1:0] == 2'b01) & addr[0]) |
                      ((Funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    assign illegal  = ~f3_legal | (~MemRead & Funct3[2]) | misalign;
`endif

    assign off    = addr_q[1:0];
    assign word_q = addr_q[DM_ADDRESS-1:2];

    always_comb begin
        size_msk = 4'b1111;
        case (f3_q[1:0])
            2'b00:   size_msk = 4'b0001;
            2'b01:   size_msk = 4'b0011;
            default: size_msk = 4'b1111;
        endcase
    end

    // Upper half of the lane mask / data pair belongs to the second word of a split access.
    assign lane_msk = (4*PW)'(size_msk) << off;
    assign wd_pair  = (32*PW)'(wdata_q) << {off, 3'b000};

    always_comb begin
        mem_addr = '0;
        mem_we   = '0;
        mem_wd   = '0;
        case (state_q)
            ACC1: begin
                mem_addr = {word_q, 2'b00};
                if (!is_ld_q) begin
                    mem_we = lane_msk[3:0];
                    mem_wd = wd_pair[31:0];
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC2: begin
                mem_addr = {word_nxt, 2'b00};
                if (!is_ld_q) begin
                    mem_we = lane_msk[7:4];
                    mem_wd = wd_pair[63:32];
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            is_ld_q   <= 1'b0;
            err_q     <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            ld_data_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            first_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (accept) begin
                        is_ld_q <= MemRead;
                        f3_q    <= Funct3;
                        addr_q  <= addr[DM_ADDRESS-1:0];
                        wdata_q <= wdata;
                        if (illegal) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= ACC1;
                        end
                    end
                end
                ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (split) begin
                        if (is_ld_q) first_q <= mem_rd;
                        state_q <= ACC2;
                    end else begin
                        if (is_ld_q) ld_data_q <= extract({32'b0, mem_rd}, off, f3_q);
                        state_q <= DONE;
                    end
`else
                    if (is_ld_q) ld_data_q <= extract({32'b0, mem_rd}, off, f3_q);
                    state_q <= DONE;
`endif
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ACC2: begin
                    if (is_ld_q) ld_data_q <= extract({mem_rd, first_q}, off, f3_q);
                    state_q <= DONE;
                end
`endif
                DONE: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == DONE) & err_q;
    assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed bench for lsu_access_ctrl with a negedge-clocked byte-lane memory model and a
// completion scoreboard; split-access steps follow the LSU_MISALIGN_SPLIT_EN build setting.
module tb_lsu_access_ctrl;
    localparam int DMA = 9;

    logic        clk, reset, req_valid, req_ready, MemRead, MemWrite;
    logic        busy, done, err;
    logic [2:0]  Funct3;
    logic [31:0] addr, wdata, ld_data, mem_wd, mem_rd;
    logic [DMA-1:0] mem_addr;
    logic [3:0]  mem_we;

    logic [31:0] mem [0:127];
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        err;
        logic        ld_chk;
        logic [31:0] ld;
    } exp_t;
    exp_t sbq[$];

    lsu_access_ctrl #(.DM_ADDRESS(DMA), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .ld_data(ld_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) mem[mem_addr[DMA-1:2]][8*i +: 8] <= mem_wd[8*i +: 8];
        mem_rd <= mem[mem_addr[DMA-1:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            chk("sb_has_entry", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_err", err, e.err);
                if (e.ld_chk) chk("sb_ld_data", ld_data, e.ld);
            end
        end
    end

    // Called at a negedge in IDLE; returns just after the accepting edge (start of cycle 1).
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic push,
                         input logic e_err, input logic e_ldc, input logic [31:0] e_ld);
        exp_t e;
        req_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; addr = a; wdata = wd;
        chk("req_ready_c0", req_ready, 1);
        if (push) begin
            e.err = e_err; e.ld_chk = e_ldc; e.ld = e_ld;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic acc(input string tag, input logic [31:0] ea, input logic [3:0] ewe,
                       input logic [31:0] ewd);
        chk({tag, ".addr"}, mem_addr, ea);
        chk({tag, ".we"}, mem_we, ewe);
        if (ewe != 4'b0000) chk({tag, ".wd"}, mem_wd, ewd);
    endtask

    task automatic single(input string tag, input logic [31:0] ea, input logic [3:0] ewe,
                          input logic [31:0] ewd);
        @(negedge clk);
        acc(tag, ea, ewe, ewd);
        chk({tag, ".done_c1"}, done, 0);
        @(negedge clk);
        chk({tag, ".done_c2"}, done, 1);
        chk({tag, ".we_c2"}, mem_we, 0);
        @(negedge clk);
    endtask

    task automatic illegal(input string tag);
        @(negedge clk);
        chk({tag, ".done_c1"}, done, 1);
        chk({tag, ".err_c1"}, err, 1);
        chk({tag, ".we_c1"}, mem_we, 0);
        @(negedge clk);
        chk({tag, ".err_c2"}, err, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem_rd = 32'h0;
        reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wd", mem_wd, 0);
        chk("rst_ld", ld_data, 0);
        chk("rst_ready", req_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 0, 0, 0);
        single("sw", 32'h10, 4'b1111, 32'hDEADBEEF);
        issue(0, 1, 3'b000, 32'h23, 32'h000000A5, 1, 0, 0, 0);
        single("sb", 32'h20, 4'b1000, 32'hA5000000);
        issue(1, 0, 3'b000, 32'h23, 32'h0, 1, 0, 1, 32'hFFFFFFA5);
        single("lb", 32'h20, 4'b0000, 32'h0);
        issue(1, 0, 3'b100, 32'h23, 32'h0, 1, 0, 1, 32'h000000A5);
        single("lbu", 32'h20, 4'b0000, 32'h0);
        issue(1, 0, 3'b001, 32'h12, 32'h0, 1, 0, 1, 32'hFFFFDEAD);
        single("lh", 32'h10, 4'b0000, 32'h0);
        issue(1, 0, 3'b101, 32'h10, 32'h0, 1, 0, 1, 32'h0000BEEF);
        single("lhu", 32'h10, 4'b0000, 32'h0);
        issue(1, 0, 3'b010, 32'h10, 32'h0, 1, 0, 1, 32'hDEADBEEF);
        single("lw", 32'h10, 4'b0000, 32'h0);
        issue(0, 1, 3'b001, 32'h16, 32'hFFFF8001, 1, 0, 0, 0);
        single("sh", 32'h14, 4'b1100, 32'h80010000);
        issue(1, 0, 3'b001, 32'h16, 32'h0, 1, 0, 1, 32'hFFFF8001);
        single("lh_back", 32'h14, 4'b0000, 32'h0);
        issue(1, 1, 3'b000, 32'h23, 32'h0, 1, 0, 1, 32'hFFFFFFA5);
        single("rd_prio", 32'h20, 4'b0000, 32'h0);

        issue(0, 1, 3'b100, 32'h20, 32'h11, 1, 1, 0, 0);
        illegal("ill_sbu");
        issue(1, 0, 3'b011, 32'h20, 32'h0, 1, 1, 0, 0);
        illegal("ill_f3_011");
        chk("ill_ld_kept", ld_data, 32'hFFFFFFA5);

        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("no_op_busy", busy, 0);

`ifdef LSU_MISALIGN_SPLIT_EN
        mem[8] = 32'h44332211; mem[9] = 32'h88776655;
        issue(1, 0, 3'b010, 32'h22, 32'h0, 1, 0, 1, 32'h66554433);
        @(negedge clk); acc("lw_split_c1", 32'h20, 4'b0000, 32'h0);
        chk("lw_split.done_c1", done, 0);
        @(negedge clk); acc("lw_split_c2", 32'h24, 4'b0000, 32'h0);
        chk("lw_split.done_c2", done, 0);
        @(negedge clk); chk("lw_split.done_c3", done, 1);
        @(negedge clk);

        issue(0, 1, 3'b001, 32'h1FF, 32'h1234, 1, 0, 0, 0);
        @(negedge clk); acc("sh_wrap_c1", 32'h1FC, 4'b1000, 32'h34000000);
        @(negedge clk); acc("sh_wrap_c2", 32'h000, 4'b0001, 32'h00000012);
        @(negedge clk); chk("sh_wrap.done_c3", done, 1);
        chk("sh_wrap.mem_hi", mem[127], 32'h34000000);
        chk("sh_wrap.mem_lo", mem[0], 32'h00000012);
        @(negedge clk);

        issue(0, 1, 3'b010, 32'h2E, 32'hCAFEBABE, 0, 0, 0, 0);
        @(negedge clk); acc("sw_rst_c1", 32'h2C, 4'b1100, 32'hBABE0000);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("sw_rst.we", mem_we, 0);
        chk("sw_rst.done", done, 0);
        chk("sw_rst.ready", req_ready, 1);
        @(negedge clk);
        chk("sw_rst.first_word", mem[11], 32'hBABE0000);
        chk("sw_rst.second_word", mem[12], 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("sw_rst.idle_done", done, 0);
`else
        issue(1, 0, 3'b010, 32'h22, 32'h0, 1, 1, 0, 0);
        illegal("mis_lw");
        issue(0, 1, 3'b001, 32'h1FF, 32'h1234, 1, 1, 0, 0);
        illegal("mis_sh");
        chk("mis_sh.mem_hi", mem[127], 32'h0);

        issue(0, 1, 3'b010, 32'h30, 32'h11223344, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("sw_rst.we", mem_we, 0);
        chk("sw_rst.done", done, 0);
        chk("sw_rst.ready", req_ready, 1);
        @(negedge clk);
        chk("sw_rst.word", mem[12], 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("sw_rst.idle_done", done, 0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_access_ctrl.md
# lsu_access_ctrl

Load/store access controller sitting between the MEM pipeline stage and the data memory, acting as the initiator of that memory's byte-lane interface. It accepts one load or store request at a time and converts it into word-aligned memory cycles with per-byte write enables, aligned store data and a sign- or zero-extended load result. Accesses that cross a 32-bit word boundary are split into two sequential memory cycles. The pipeline is stalled via `busy` while a request is in flight.

## Interface
- `DM_ADDRESS`, 9: byte-address width of the data memory.
- `DATA_W`, 32: data width. Only 32 is supported.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high in IDLE only; a request is accepted when `req_valid & req_ready & (MemRead | MemWrite)`.
- `MemRead`  in  1  load request.
- `MemWrite`  in  1  store request.
- `Funct3`  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address. Only bits `[DM_ADDRESS-1:0]` are used.
- `wdata`  in  32  store data, right-justified.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse when the request completes.
- `err`  out  1  valid with `done`: request was illegal, and no memory write occurred.
- `ld_data`  out  32  load result; held stable from `done` until the next `done`.
- `mem_addr`  out  `DM_ADDRESS`  word address, low 2 bits always 0.
- `mem_we`  out  4  byte write enables; lane i is bits `[8i+7:8i]`, little-endian.
- `mem_wd`  out  32  lane-aligned write data.
- `mem_rd`  in  32  read data for `mem_addr`. The memory is negedge-clocked, so `mem_rd` is valid before the rising edge that ends the cycle in which `mem_addr` is driven.

## Operation
- **States:** IDLE, ACC1, ACC2, DONE.
- **IDLE:** on accept, register the operation, `Funct3`, the address and `wdata`.
  - Legal request: go to ACC1.
  - Illegal request: go to DONE with `err=1`.
- **Priority:** if both `MemRead` and `MemWrite` are set, the request is treated as a load. A `req_valid` with neither set is ignored.
- **Illegal encodings:**
  - any `Funct3` other than 000, 001, 010, 100, 101;
  - a store with `Funct3` 100 or 101.
- **Derived values:** `off = addr[1:0]`; size `sz` is 1, 2 or 4 bytes. An access is split when `off + sz > 4`.
- **ACC1:**
  - `mem_addr = {addr[DM_ADDRESS-1:2], 2'b00}`.
  - Store: `mem_we = ((1<<sz)-1) << off`, truncated to 4 bits; `mem_wd = wdata << 8*off`.
  - Load: capture `mem_rd` at the end of the cycle.
  - Next state: ACC2 if split, else DONE.
- **ACC2:**
  - `mem_addr` = next word index; the index wraps modulo 2^(`DM_ADDRESS`-2).
  - Store: `mem_we` = remaining low lanes; `mem_wd = wdata >> 8*(4-off)`.
  - Load: capture `mem_rd` into the upper part of a 64-bit assembly register.
  - Next state: DONE.
- **Load extraction:**
  - Raw value = `{second, first} >> 8*off`, taking the low `sz` bytes.
  - B/H: sign-extend from bit 7 or bit 15. BU/HU: zero-extend. W: unchanged.
- **DONE:** pulse `done` (plus `err` if set), update `ld_data` for loads, return to IDLE.
- `mem_we` is 0 in every state other than ACC1 and ACC2, and 0 in those states for loads.
- `err` pulses only together with `done`.

## Timing
- Request accepted in cycle 0.
  - Single access: ACC1 in cycle 1, `done` in cycle 2.
  - Split access: ACC1 in cycle 1, ACC2 in cycle 2, `done` in cycle 3.
  - Illegal request: `done` and `err` in cycle 1.
- The next request can be accepted in the cycle after `done`.
- **Reset values:** state IDLE; `busy=0`, `done=0`, `err=0`, `mem_we=0`, `mem_addr=0`, `mem_wd=0`, `ld_data=0`; `req_ready=1`.
- **Reset mid-operation:** `mem_we` drops to 0 immediately and no `done` is produced. A split store reset after ACC1 leaves its first part written.

## Configuration
- **`LSU_MISALIGN_SPLIT_EN` defined:** behaviour exactly as above, including split accesses.
- **`LSU_MISALIGN_SPLIT_EN` undefined:** any non-naturally-aligned access is illegal: H with `off[0]=1`, or W with `off!=0`.
  - Such a request goes IDLE -> DONE with `err=1` in cycle 1, with no memory cycle.
  - ACC2 is not synthesized.

## Test plan
- **Aligned SW:** `addr=0x10`, `wdata=0xDEADBEEF` -> cycle 1: `mem_addr=0x10`, `mem_we=1111`, `mem_wd=0xDEADBEEF`; `done` in cycle 2, `err=0`.
- **SB and LB:**
  - SB `addr=0x23`, `wdata=0x000000A5` -> `mem_we=1000`, `mem_wd=0xA5000000`.
  - Then LB `addr=0x23` -> `ld_data=0xFFFFFFA5`.
  - LBU `addr=0x23` -> `ld_data=0x000000A5`.
- **Split LW (macro defined):** memory word 0x20=0x44332211, word 0x24=0x88776655; LW `addr=0x22` -> cycle 1 `mem_addr=0x20`, cycle 2 `mem_addr=0x24`, `done` in cycle 3 with `ld_data=0x66554433`.
- **Split SH at the top word (macro defined):** SH `addr=0x1FF`, `wdata=0x1234` -> cycle 1: `mem_addr=0x1FC`, `mem_we=1000`, `mem_wd=0x34000000`; cycle 2: `mem_addr=0x000` (wrap), `mem_we=0001`, `mem_wd=0x00000012`.
- **Illegal and misaligned requests:**
  - Store with `Funct3=100` -> `done` and `err` in cycle 1, `mem_we` never nonzero.
  - Macro undefined: LW `addr=0x22` -> `done` and `err` in cycle 1.
- **Reset during split store:** assert `reset` in cycle 2 -> `mem_we=0` the same cycle, no `done`, `req_ready=1`; the first word's lanes remain written.
